// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline sequencer for the 5-stage MIPS core. Owns the PC write enable and
//   every stall/flush strobe of IF/ID, ID/EX and EX/MEM. Resolves load-use
//   hazards, taken branches (resolved in EX), jumps (resolved in ID) and
//   interrupt entry.
//
//   State table:
//     state       | meaning
//     RUN         | normal flow, hazards resolved combinationally
//     LU_HOLD     | extra load-use hold cycles beyond the first
//     IRQ_ENTER   | one-cycle interrupt entry (irq_take)
//     ISR         | in interrupt service routine, behaves as RUN, irq ignored
//
// Ports
//   clk, reset (sync, active-low)
//   id_rs/id_rt/id_uses_rs/id_uses_rt/id_isJ/id_isBranch : ID-stage decode
//   ex_memrd/ex_wr_reg/ex_br_taken                        : EX-stage status
//   irq (level), irq_done (pulse at ISR return)
//   pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush   : pipeline control
//   irq_take (entry pulse), in_isr (ISR active)

module hazard_sequencer #(
    parameter int LU_BUBBLES   = 1,
    parameter int IRQ_WAIT_MAX = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_isJ,
    input  logic       id_isBranch,
    input  logic       ex_memrd,
    input  logic [4:0] ex_wr_reg,
    input  logic       ex_br_taken,
    input  logic       irq,
    input  logic       irq_done,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       irq_take,
    output logic       in_isr
);

    localparam int WW = $clog2(IRQ_WAIT_MAX + 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(IRQ_WAIT_MAX);
    localparam logic [1:0]    LU_INIT  = 2'(LU_BUBBLES - 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LU_HOLD   = 2'd1,
        S_IRQ_ENTER = 2'd2,
        S_ISR       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    lu_cnt_q, lu_cnt_d;
    logic          irq_pend_q, irq_pend_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          in_isr_q, in_isr_d;
    // Tracks whether the instruction now in EX is a conditional branch.
    logic          ex_isbr_q, ex_isbr_d;

    logic lu_hit;
    logic safe_slot;
    logic forced;
    logic irq_go;
    logic irq_done_ok;
    state_t home;

    assign lu_hit = ex_memrd && (ex_wr_reg != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_wr_reg)) ||
                     (id_uses_rt && (id_rt == ex_wr_reg)));

    assign safe_slot = (state_q == S_RUN) && !lu_hit && !id_isJ &&
                       !id_isBranch && !ex_br_taken;

    // A starved request may also preempt a load-use hold.
    assign forced = irq_pend_q && (wait_q == WAIT_MAX) && !ex_br_taken &&
                    ((state_q == S_RUN) || (state_q == S_LU_HOLD));

    assign irq_go      = irq_pend_q && (safe_slot || forced);
    assign irq_done_ok = irq_done && in_isr_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_RUN;
            lu_cnt_q   <= 2'd0;
            irq_pend_q <= 1'b0;
            wait_q     <= '0;
            in_isr_q   <= 1'b0;
            ex_isbr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            irq_pend_q <= irq_pend_d;
            wait_q     <= wait_d;
            in_isr_q   <= in_isr_d;
            ex_isbr_q  <= ex_isbr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        in_isr_d = in_isr_q;
        if (irq_done_ok) begin
            in_isr_d = 1'b0;
        end
        home = in_isr_d ? S_ISR : S_RUN;

        case (state_q)
            S_RUN, S_ISR: begin
                state_d = home;
                if (ex_br_taken) begin
                    state_d = home;
                end else if (irq_go) begin
                    state_d = S_IRQ_ENTER;
                end else if (lu_hit && (LU_BUBBLES > 1)) begin
                    state_d  = S_LU_HOLD;
                    lu_cnt_d = LU_INIT;
                end
            end
            S_LU_HOLD: begin
                if (ex_br_taken) begin
                    state_d  = home;
                    lu_cnt_d = 2'd0;
                end else if (irq_go) begin
                    state_d  = S_IRQ_ENTER;
                    lu_cnt_d = 2'd0;
                end else if (lu_cnt_q <= 2'd1) begin
                    state_d  = home;
                    lu_cnt_d = 2'd0;
                end else begin
                    lu_cnt_d = lu_cnt_q - 2'd1;
                end
            end
            S_IRQ_ENTER: begin
                state_d  = S_ISR;
                lu_cnt_d = 2'd0;
                in_isr_d = 1'b1;
            end
            default: begin
                state_d  = S_RUN;
                lu_cnt_d = 2'd0;
            end
        endcase

        // Pending uses the registered in_isr, so an irq coincident with
        // irq_done is latched one cycle later.
        irq_pend_d = irq_pend_q || (irq && !in_isr_q);
        if (!irq_pend_q) begin
            wait_d = '0;
        end else if (wait_q == WAIT_MAX) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 1'b1;
        end
        if (state_q == S_IRQ_ENTER) begin
            irq_pend_d = 1'b0;
            wait_d     = '0;
        end

        ex_isbr_d = idex_flush ? 1'b0 : id_isBranch;
    end

    // Output logic
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        irq_take    = 1'b0;

        case (state_q)
            S_RUN, S_ISR: begin
                if (ex_br_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (irq_go) begin
                    // entry cycle: hazards are superseded by IRQ_ENTER flushes
                end else if (lu_hit) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_isJ) begin
                    ifid_flush = 1'b1;
                end
            end
            S_LU_HOLD: begin
                if (ex_br_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (!irq_go) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            S_IRQ_ENTER: begin
                irq_take    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                // A branch already in EX is squashed and re-executed on return.
                exmem_flush = !ex_memrd && ex_isbr_q;
            end
            default: begin
                pc_we = 1'b1;
            end
        endcase
    end

    assign in_isr = in_isr_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer (LU_BUBBLES=3, IRQ_WAIT_MAX=7).
// Stimulus drives inputs just after posedge and pushes the expected output
// vector {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, irq_take,
// in_isr}; a monitor pops and compares on every negedge.

module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wr_reg;
    logic       id_uses_rs, id_uses_rt, id_isJ, id_isBranch;
    logic       ex_memrd, ex_br_taken, irq, irq_done;
    logic       pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
    logic       irq_take, in_isr;

    localparam logic [6:0] NORM = 7'b1100000;
    localparam logic [6:0] HOLD = 7'b0001000;
    localparam logic [6:0] BRF  = 7'b1111000;
    localparam logic [6:0] JMP  = 7'b1110000;
    localparam logic [6:0] ENT  = 7'b1111010;
    localparam logic [6:0] ENTX = 7'b1111110;
    localparam logic [6:0] ISRN = 7'b1100001;
    localparam logic [6:0] ISRJ = 7'b1110001;

    logic [6:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] got;

    hazard_sequencer #(.LU_BUBBLES(3), .IRQ_WAIT_MAX(7)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_isJ(id_isJ), .id_isBranch(id_isBranch),
        .ex_memrd(ex_memrd), .ex_wr_reg(ex_wr_reg), .ex_br_taken(ex_br_taken),
        .irq(irq), .irq_done(irq_done),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .irq_take(irq_take), .in_isr(in_isr)
    );

    always #5 clk = ~clk;

    assign got = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, irq_take, in_isr};

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got=%b expected=%b (pc_we,ifid_we,ifid_fl,idex_fl,exmem_fl,irq_take,in_isr) t=%0t",
                         n, got, e, $time);
            end
        end
    end

    task automatic idle();
        reset = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0; ex_wr_reg = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_isJ = 1'b0; id_isBranch = 1'b0;
        ex_memrd = 1'b0; ex_br_taken = 1'b0; irq = 1'b0; irq_done = 1'b0;
    endtask

    // Current inputs apply for one cycle; the expected outputs are queued.
    task automatic cyc(input logic [6:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lw_hit_rs(input logic [4:0] r);
        ex_memrd = 1'b1; ex_wr_reg = r; id_rs = r; id_uses_rs = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        tick(); tick();
        idle();
        cyc(NORM, "reset_state");

        // load-use on rs: three hold cycles then resume
        lw_hit_rs(5'd8);
        cyc(HOLD, "lu_rs_hit");
        ex_memrd = 1'b0;
        cyc(HOLD, "lu_hold_1");
        cyc(HOLD, "lu_hold_2");
        cyc(NORM, "lu_resume");

        // $0 never hazards
        idle(); lw_hit_rs(5'd0); id_uses_rt = 1'b1;
        cyc(NORM, "lu_r0");

        // register match but rs unused
        idle(); lw_hit_rs(5'd5); id_uses_rs = 1'b0;
        cyc(NORM, "lu_rs_unused");

        // load-use on rt
        idle(); ex_memrd = 1'b1; ex_wr_reg = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        cyc(HOLD, "lu_rt_hit");
        ex_memrd = 1'b0;
        cyc(HOLD, "lu_rt_hold_1");
        cyc(HOLD, "lu_rt_hold_2");
        idle();
        cyc(NORM, "lu_rt_resume");

        // taken branch beats load-use
        lw_hit_rs(5'd8); ex_br_taken = 1'b1;
        cyc(BRF, "br_over_lu");
        idle();
        cyc(NORM, "br_no_hold");

        // jump
        id_isJ = 1'b1;
        cyc(JMP, "jump_flush");
        idle();

        // taken branch aborts a hold
        lw_hit_rs(5'd4);
        cyc(HOLD, "abort_lu_hit");
        idle(); ex_br_taken = 1'b1;
        cyc(BRF, "abort_br");
        idle();
        cyc(NORM, "abort_run");

        // irq_done outside ISR ignored
        irq_done = 1'b1;
        cyc(NORM, "done_outside_isr");
        idle();

        // irq while beq in ID for three cycles, then first safe slot
        irq = 1'b1; id_isBranch = 1'b1;
        cyc(NORM, "irq_beq_0");
        cyc(NORM, "irq_beq_1");
        cyc(NORM, "irq_beq_2");
        id_isBranch = 1'b0;
        cyc(NORM, "irq_safe");
        cyc(ENT, "irq_take_safe");
        cyc(ISRN, "isr_irq_0");
        cyc(ISRN, "isr_irq_1");
        id_isJ = 1'b1;
        cyc(ISRJ, "isr_jump");
        id_isJ = 1'b0;
        // irq_done with irq: pend latches one cycle later
        irq_done = 1'b1;
        cyc(ISRN, "isr_done_irq");
        irq_done = 1'b0;
        cyc(NORM, "post_done_irq");
        irq = 1'b0;
        cyc(NORM, "second_safe");
        cyc(ENT, "second_take");
        irq_done = 1'b1;
        cyc(ISRN, "second_done");
        idle();
        cyc(NORM, "second_exit");

        // forced entry with a jump in ID every cycle
        irq = 1'b1; id_isJ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(JMP, $sformatf("force_wait_%0d", k));
        end
        id_isJ = 1'b0; id_isBranch = 1'b1;
        cyc(NORM, "force_decide");
        id_isBranch = 1'b0;
        cyc(ENTX, "force_take_exmem");
        cyc(ISRN, "force_isr");
        irq = 1'b0; irq_done = 1'b1;
        cyc(ISRN, "force_done");
        idle();
        cyc(NORM, "force_exit");

        // reset during a load-use hold
        lw_hit_rs(5'd8);
        cyc(HOLD, "rst_lu_hit");
        idle(); reset = 1'b0;
        tick();
        idle();
        cyc(NORM, "rst_lu_after");

        // reset with an irq pending leaves nothing behind
        irq = 1'b1;
        cyc(NORM, "rst_pend_raise");
        idle(); reset = 1'b0;
        tick();
        idle();
        cyc(NORM, "rst_pend_0");
        cyc(NORM, "rst_pend_1");

        // reset during IRQ_ENTER
        irq = 1'b1;
        cyc(NORM, "rst_ent_raise");
        irq = 1'b0;
        cyc(NORM, "rst_ent_decide");
        reset = 1'b0;
        tick();
        idle();
        cyc(NORM, "rst_ent_after_0");
        cyc(NORM, "rst_ent_after_1");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
